// File: rtl/fc_pkg.sv
// Shared definitions for the FC weight path: buffer geometry, row type and
// the weight-loader state encoding.
package fc_pkg;

    localparam int FC_SIZE  = 16;
    localparam int FC_AW    = 7;
    localparam int FC_DEPTH = 128;

    typedef byte fc_row_t [FC_SIZE];

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FILL  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } fc_ld_state_e;

endpackage

// File: rtl/fc_w_row_packer.sv
// Packs IN_BYTES-wide beats into one FC_SIZE-lane row. Beats enter at the top
// lanes and shift down, so after BEATS beats beat b sits at lanes b*IN_BYTES+k.
module fc_w_row_packer #(
    parameter int FC_SIZE  = 16,
    parameter int IN_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_beat_en,
    input  logic [8*IN_BYTES-1:0]   i_beat,
    output logic                    o_row_full,
    output logic [8*FC_SIZE-1:0]    o_row
);

    localparam int BEATS  = FC_SIZE / IN_BYTES;
    localparam int ROW_W  = 8 * FC_SIZE;
    localparam int BEAT_W = 8 * IN_BYTES;
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [CW-1:0]    r_beat_cnt;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_next;
    logic             w_last;

    always_comb begin
        w_row_next = (r_row >> BEAT_W) | (ROW_W'(i_beat) << (ROW_W - BEAT_W));
        w_last     = (r_beat_cnt == LAST_BEAT);
        o_row_full = i_beat_en && w_last;
        o_row      = w_row_next;
    end

    // A partial row needs no explicit flush: a full row always overwrites
    // every lane, so restarting the beat count is enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_row      <= '0;
        end else if (i_clr) begin
            r_beat_cnt <= '0;
        end else if (i_beat_en) begin
            r_row      <= w_row_next;
            r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fc_w_loader.sv
// FC weight-buffer feeder: collects a valid/ready byte stream into full rows
// and writes each row to consecutive (wrapping) buffer addresses.
module fc_w_loader
    import fc_pkg::*;
#(
    parameter int FC_SIZE  = 16,
    parameter int IN_BYTES = 4,
    parameter int AW       = FC_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [AW-1:0]           base_addr_i,
    input  logic [7:0]              num_rows_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [8*IN_BYTES-1:0]   s_data_i,
    output logic                    wren_o,
    output logic [FC_SIZE*AW-1:0]   wrptr_o,
    output logic [8*FC_SIZE-1:0]    weight_o,
    output logic                    busy_o,
    output logic                    done_o
);

    fc_ld_state_e r_state, w_state_next;

    logic [AW-1:0]          r_base;
    logic [7:0]             r_num_rows;
    logic [7:0]             r_row_cnt;
    logic                   r_wren;
    logic [FC_SIZE*AW-1:0]  r_wrptr;
    logic [8*FC_SIZE-1:0]   r_weight;

    logic [7:0]             w_num_sat;
    logic [AW-1:0]          w_addr;
    logic                   w_last_row;
    logic                   w_start;
    logic                   w_beat_en;
    logic                   w_row_full;
    logic [8*FC_SIZE-1:0]   w_row;

    fc_w_row_packer #(
        .FC_SIZE  (FC_SIZE),
        .IN_BYTES (IN_BYTES)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start),
        .i_beat_en  (w_beat_en),
        .i_beat     (s_data_i),
        .o_row_full (w_row_full),
        .o_row      (w_row)
    );

    always_comb begin
        w_num_sat  = (num_rows_i > 8'd128) ? 8'd128 : num_rows_i;
        w_addr     = r_base + AW'(r_row_cnt);
        w_last_row = (({1'b0, r_row_cnt} + 9'd1) == {1'b0, r_num_rows});
        w_start    = (r_state == LD_IDLE) && start_i;
        w_beat_en  = (r_state == LD_FILL) && s_valid_i;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            LD_IDLE: begin
                if (start_i)
                    w_state_next = (w_num_sat == 8'd0) ? LD_DONE : LD_FILL;
            end
            LD_FILL: begin
                if (w_row_full)
                    w_state_next = LD_WRITE;
            end
            LD_WRITE: begin
                w_state_next = w_last_row ? LD_DONE : LD_FILL;
            end
            LD_DONE: begin
                w_state_next = LD_IDLE;
            end
            default: w_state_next = LD_IDLE;
        endcase
    end

    // Write-side outputs are loaded on the edge that accepts the last beat,
    // so they are valid during the WRITE cycle that follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LD_IDLE;
            r_base     <= '0;
            r_num_rows <= '0;
            r_row_cnt  <= '0;
            r_wren     <= 1'b0;
            r_wrptr    <= '0;
            r_weight   <= '0;
        end else begin
            r_state <= w_state_next;
            r_wren  <= (r_state == LD_FILL) && w_row_full;
            if (w_start) begin
                r_base     <= base_addr_i;
                r_num_rows <= w_num_sat;
                r_row_cnt  <= '0;
            end
            if ((r_state == LD_FILL) && w_row_full) begin
                r_wrptr  <= {FC_SIZE{w_addr}};
                r_weight <= w_row;
            end
            if (r_state == LD_WRITE)
                r_row_cnt <= r_row_cnt + 8'd1;
        end
    end

    always_comb begin
        s_ready_o = (r_state == LD_FILL);
        busy_o    = (r_state == LD_FILL) || (r_state == LD_WRITE);
        done_o    = (r_state == LD_DONE);
        wren_o    = r_wren;
        wrptr_o   = r_wrptr;
        weight_o  = r_weight;
    end

endmodule
